// File: rtl/ddr3_port_arbiter_if.sv
// Requester-side bundle of the DDR3 port arbiter: per-port request payloads,
// acceptance pulses and the shared read-response bus.
interface ddr3_port_arbiter_if #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 27,
    parameter int DataWidth = 256
);
    localparam int MaskWidth = DataWidth / 8;

    logic [NumReq-1:0]                 req_valid_i;
    logic [NumReq-1:0]                 req_write_i;
    logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i;
    logic [NumReq-1:0][DataWidth-1:0]  req_wdata_i;
    logic [NumReq-1:0][MaskWidth-1:0]  req_wmask_i;
    logic [NumReq-1:0]                 req_ready_o;
    logic [NumReq-1:0]                 rsp_valid_o;
    logic [DataWidth-1:0]              rsp_data_o;

    // Arbiter side
    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

    // Requester side
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter that funnels several requester ports into one DDR3
// user-interface command/write-data channel and routes returning read data
// back to the issuing port through an in-order tracking FIFO.
module ddr3_port_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 27,
    parameter int DataWidth = 256,
    parameter int MaxRdOut  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   calib_done_i,
    ddr3_port_arbiter_if.slave     req_if,
    input  logic                   cmd_ready_i,
    output logic                   cmd_en_o,
    output logic [2:0]             cmd_o,
    output logic [AddrWidth-1:0]   addr_o,
    input  logic                   wr_data_rdy_i,
    output logic                   wr_data_en_o,
    output logic                   wr_data_end_o,
    output logic [DataWidth-1:0]   wr_data_o,
    output logic [DataWidth/8-1:0] wr_data_mask_o,
    input  logic                   rd_data_valid_i,
    input  logic [DataWidth-1:0]   rd_data_i,
    output logic                   busy_o,
    output logic                   rd_err_o
);
    localparam int MaskWidth = DataWidth / 8;
    localparam int IdxW      = $clog2(NumReq);
    localparam int PtrW      = (MaxRdOut > 1) ? $clog2(MaxRdOut) : 1;
    localparam int CntW      = $clog2(MaxRdOut + 1);

    localparam logic [2:0] CmdWrite = 3'b000;
    localparam logic [2:0] CmdRead  = 3'b001;

    typedef enum logic [1:0] {
        StWaitCalib,
        StIdle,
        StCmd,
        StWdata
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     lastGrant_q;
    logic [IdxW-1:0]     fifoMem_q [MaxRdOut];
    logic [PtrW-1:0]     wrPtr_q, rdPtr_q;
    logic [CntW-1:0]     fifoCount_q;
    logic                rdErr_q;

    logic [NumReq-1:0]   eligible;
    logic                found;
    logic [IdxW-1:0]     pick;
    logic [IdxW-1:0]     searchIdx;
    logic                fifoFull, fifoEmpty;
    logic                grantWrite;
    logic                grantNow;
    logic                fifoPush, fifoPop;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxRdOut - 1)) ? '0 : p + 1'b1;
    endfunction

    // lastGrant_q doubles as the index of the port currently being served.
    assign fifoFull   = (fifoCount_q == CntW'(MaxRdOut));
    assign fifoEmpty  = (fifoCount_q == '0);
    assign eligible   = req_if.req_valid_i & (req_if.req_write_i | {NumReq{~fifoFull}});
    assign grantWrite = req_if.req_write_i[lastGrant_q];
    assign grantNow   = (state_q == StIdle) && calib_done_i && found;
    assign fifoPush   = (state_q == StCmd) && cmd_ready_i && !grantWrite;
    assign fifoPop    = rd_data_valid_i && !fifoEmpty;
    assign rd_err_o   = rdErr_q;

    // Round-robin search starting just after the last granted port
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        searchIdx = '0;
        for (int k = 1; k <= NumReq; k++) begin
            searchIdx = IdxW'((int'(lastGrant_q) + k) % NumReq);
            if (!found && eligible[searchIdx]) begin
                found = 1'b1;
                pick  = searchIdx;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StWaitCalib;
        else       state_q <= state_d;
    end

    // Next-state logic; calibration loss only blocks new grants from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitCalib: if (calib_done_i) state_d = StIdle;
            StIdle:      if (grantNow) state_d = StCmd;
            StCmd:       if (cmd_ready_i) state_d = grantWrite ? StWdata : StIdle;
            StWdata:     if (wr_data_rdy_i) state_d = StIdle;
            default:     state_d = StWaitCalib;
        endcase
    end

    // Controller-side outputs and acceptance pulses, zero outside their phase
    always_comb begin
        cmd_en_o           = 1'b0;
        cmd_o              = CmdWrite;
        addr_o             = '0;
        wr_data_en_o       = 1'b0;
        wr_data_end_o      = 1'b0;
        wr_data_o          = '0;
        wr_data_mask_o     = '0;
        busy_o             = 1'b0;
        req_if.req_ready_o = '0;
        case (state_q)
            StCmd: begin
                busy_o   = 1'b1;
                cmd_en_o = 1'b1;
                cmd_o    = grantWrite ? CmdWrite : CmdRead;
                addr_o   = req_if.req_addr_i[lastGrant_q];
                if (cmd_ready_i && !grantWrite) req_if.req_ready_o[lastGrant_q] = 1'b1;
            end
            StWdata: begin
                busy_o         = 1'b1;
                wr_data_en_o   = 1'b1;
                wr_data_end_o  = 1'b1;
                wr_data_o      = req_if.req_wdata_i[lastGrant_q];
                wr_data_mask_o = MaskWidth'(req_if.req_wmask_i[lastGrant_q]);
                if (wr_data_rdy_i) req_if.req_ready_o[lastGrant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Route returning read data to the oldest outstanding reader
    always_comb begin
        req_if.rsp_valid_o = '0;
        req_if.rsp_data_o  = '0;
        if (fifoPop) begin
            req_if.rsp_valid_o[fifoMem_q[rdPtr_q]] = 1'b1;
            req_if.rsp_data_o                      = rd_data_i;
        end
    end

    // Remember the granted port so the search rotates past it next time
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         lastGrant_q <= IdxW'(NumReq - 1);
        else if (grantNow) lastGrant_q <= pick;
    end

    // Tracking FIFO storage; contents are meaningless while the count is zero
    always_ff @(posedge clk_i) begin
        if (fifoPush) fifoMem_q[wrPtr_q] <= lastGrant_q;
    end

    // Tracking FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (fifoPush) wrPtr_q <= ptrInc(wrPtr_q);
            if (fifoPop)  rdPtr_q <= ptrInc(rdPtr_q);
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount_q <= fifoCount_q + 1'b1;
                2'b01:   fifoCount_q <= fifoCount_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky flag for read data arriving with nothing outstanding
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              rdErr_q <= 1'b0;
        else if (rd_data_valid_i && fifoEmpty)  rdErr_q <= 1'b1;
    end
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Bench for ddr3_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ddr3_port_arbiter;
    localparam int NumReq    = 2;
    localparam int AddrWidth = 27;
    localparam int DataWidth = 256;
    localparam int MaxRdOut  = 4;
    localparam int MaskWidth = DataWidth / 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 calibDone, cmdReady, wrDataRdy, rdDataValid;
    logic [DataWidth-1:0] rdData;
    logic                 cmdEn, wrDataEn, wrDataEnd, busy, rdErr;
    logic [2:0]           cmd;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wrData;
    logic [MaskWidth-1:0] wrDataMask;

    ddr3_port_arbiter_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) reqIf();

    ddr3_port_arbiter #(
        .NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MaxRdOut(MaxRdOut)
    ) dut (
        .clk_i(clock), .rst_i(reset), .calib_done_i(calibDone), .req_if(reqIf),
        .cmd_ready_i(cmdReady), .cmd_en_o(cmdEn), .cmd_o(cmd), .addr_o(addr),
        .wr_data_rdy_i(wrDataRdy), .wr_data_en_o(wrDataEn), .wr_data_end_o(wrDataEnd),
        .wr_data_o(wrData), .wr_data_mask_o(wrDataMask),
        .rd_data_valid_i(rdDataValid), .rd_data_i(rdData),
        .busy_o(busy), .rd_err_o(rdErr)
    );

    // Free-running clock
    always #5 clock = ~clock;

    int testsRun;
    int failCount;
    int cycle;

    // Reference model: which port is being served (-1 none), whether its
    // command has gone out, outstanding readers in issue order, sticky error.
    bit   mCalib;
    int   mCur;
    bit   mInData;
    int   mLast;
    int   mQ[$];
    bit   mErr;

    logic [1:0] expReadyLast;
    logic [1:0] readyVal[$];
    int         readyCycle[$];
    logic [1:0] rspVal[$];
    int         wrEnCount;

    function automatic logic [DataWidth-1:0] randData();
        logic [DataWidth-1:0] d;
        for (int i = 0; i < DataWidth / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mCalib  = 1'b0;
        mCur    = -1;
        mInData = 1'b0;
        mLast   = NumReq - 1;
        mQ.delete();
        mErr    = 1'b0;
    endtask

    task automatic newRequest(input int p, input logic isWrite);
        reqIf.req_valid_i[p] = 1'b1;
        reqIf.req_write_i[p] = isWrite;
        reqIf.req_addr_i[p]  = AddrWidth'($urandom);
        reqIf.req_wdata_i[p] = randData();
        reqIf.req_wmask_i[p] = MaskWidth'($urandom);
    endtask

    // One clock cycle: check outputs mid-cycle against the model, log what
    // the DUT did, then advance the model on the rising edge.
    task automatic applyStimulus();
        logic [1:0]           eReady, eRsp;
        logic [DataWidth-1:0] eRspData;
        logic                 eCmdEn, eWdEn;
        int                   g, occ;
        #4;
        if (reset) modelReset();
        g      = (mCur >= 0) ? mCur : 0;
        eCmdEn = (mCur >= 0) && !mInData;
        eWdEn  = (mCur >= 0) && mInData;
        eReady = '0;
        if (eCmdEn && cmdReady && !reqIf.req_write_i[g]) eReady[g] = 1'b1;
        if (eWdEn && wrDataRdy) eReady[g] = 1'b1;
        eRsp     = '0;
        eRspData = '0;
        if (rdDataValid && mQ.size() > 0) begin
            eRsp[mQ[0]] = 1'b1;
            eRspData    = rdData;
        end
        checkOutput("cmd_en", cmdEn, eCmdEn);
        checkOutput("cmd", cmd, (eCmdEn && !reqIf.req_write_i[g]) ? 3'b001 : 3'b000);
        checkOutput("addr", addr, eCmdEn ? reqIf.req_addr_i[g] : '0);
        checkOutput("wr_data_en", wrDataEn, eWdEn);
        checkOutput("wr_data_end", wrDataEnd, eWdEn);
        checkOutput("wr_data", wrData, eWdEn ? reqIf.req_wdata_i[g] : '0);
        checkOutput("wr_data_mask", wrDataMask, eWdEn ? reqIf.req_wmask_i[g] : '0);
        checkOutput("req_ready", reqIf.req_ready_o, eReady);
        checkOutput("rsp_valid", reqIf.rsp_valid_o, eRsp);
        checkOutput("rsp_data", reqIf.rsp_data_o, eRspData);
        checkOutput("busy", busy, mCur >= 0);
        checkOutput("rd_err", rdErr, mErr);
        if (reqIf.req_ready_o != '0) begin
            readyVal.push_back(reqIf.req_ready_o);
            readyCycle.push_back(cycle);
        end
        if (reqIf.rsp_valid_o != '0) rspVal.push_back(reqIf.rsp_valid_o);
        if (wrDataEn === 1'b1) wrEnCount++;
        expReadyLast = eReady;
        @(posedge clock);
        if (reset) modelReset();
        else begin
            occ = mQ.size();
            if (rdDataValid) begin
                if (occ > 0) void'(mQ.pop_front());
                else         mErr = 1'b1;
            end
            if (mCur >= 0) begin
                if (!mInData) begin
                    if (cmdReady) begin
                        if (reqIf.req_write_i[mCur]) mInData = 1'b1;
                        else begin
                            mQ.push_back(mCur);
                            mCur = -1;
                        end
                    end
                end else if (wrDataRdy) begin
                    mCur    = -1;
                    mInData = 1'b0;
                end
            end else if (!mCalib) begin
                if (calibDone) mCalib = 1'b1;
            end else if (calibDone) begin
                for (int k = 1; k <= NumReq; k++) begin
                    int p;
                    p = (mLast + k) % NumReq;
                    if (mCur < 0 && reqIf.req_valid_i[p] &&
                        (reqIf.req_write_i[p] || occ < MaxRdOut)) begin
                        mCur  = p;
                        mLast = p;
                    end
                end
            end
        end
        cycle++;
        #1;
    endtask

    // Acknowledged ports immediately issue a fresh request of the same kind
    task automatic renewAcked();
        for (int p = 0; p < NumReq; p++)
            if (expReadyLast[p]) newRequest(p, reqIf.req_write_i[p]);
    endtask

    // Random requester/controller behaviour that still obeys the handshake
    task automatic driveRandomCycle();
        calibDone   = ($urandom_range(0, 7) != 0);
        cmdReady    = ($urandom_range(0, 3) != 0);
        wrDataRdy   = ($urandom_range(0, 3) != 0);
        rdDataValid = (mQ.size() > 0) && ($urandom_range(0, 1) == 1);
        rdData      = randData();
        for (int p = 0; p < NumReq; p++) begin
            if (expReadyLast[p]) reqIf.req_valid_i[p] = 1'b0;
            if (!reqIf.req_valid_i[p] && $urandom_range(0, 2) == 0)
                newRequest(p, 1'($urandom_range(0, 1)));
        end
        applyStimulus();
    endtask

    initial begin
        testsRun     = 0;
        failCount    = 0;
        cycle        = 0;
        wrEnCount    = 0;
        expReadyLast = '0;
        reset        = 1'b1;
        calibDone    = 1'b0;
        cmdReady     = 1'b0;
        wrDataRdy    = 1'b0;
        rdDataValid  = 1'b0;
        rdData       = '0;
        reqIf.req_valid_i = '0;
        reqIf.req_write_i = '0;
        reqIf.req_addr_i  = '0;
        reqIf.req_wdata_i = '0;
        reqIf.req_wmask_i = '0;
        modelReset();
        @(posedge clock);
        #1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        // Requests are ignored until calibration completes
        newRequest(0, 1'b0);
        repeat (20) applyStimulus();
        checkOutput("calibGateCmdEn", cmdEn, 1'b0);
        calibDone = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("calibCmdEnTwoCycles", cmdEn, 1'b1);
        cmdReady = 1'b1;
        applyStimulus();
        reqIf.req_valid_i = '0;
        rdDataValid = 1'b1;
        rdData      = randData();
        applyStimulus();
        rdDataValid = 1'b0;

        // Two continuous readers alternate starting from port 0 after reset
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
        readyVal.delete();
        readyCycle.delete();
        newRequest(0, 1'b0);
        newRequest(1, 1'b0);
        repeat (8) begin
            applyStimulus();
            renewAcked();
        end
        reqIf.req_valid_i = '0;
        checkOutput("rrCount", readyVal.size(), 4);
        if (readyVal.size() == 4) begin
            checkOutput("rrOrder0", readyVal[0], 2'b01);
            checkOutput("rrOrder1", readyVal[1], 2'b10);
            checkOutput("rrOrder2", readyVal[2], 2'b01);
            checkOutput("rrOrder3", readyVal[3], 2'b10);
            for (int i = 0; i < 3; i++)
                checkOutput("rrSpacing", readyCycle[i+1] - readyCycle[i], 2);
        end
        rdDataValid = 1'b1;
        repeat (4) begin
            rdData = randData();
            applyStimulus();
        end
        rdDataValid = 1'b0;

        // Write from port 1 with the write-data handshake delayed
        readyVal.delete();
        wrEnCount = 0;
        newRequest(1, 1'b1);
        reqIf.req_addr_i[1] = 27'h0001234;
        cmdReady  = 1'b1;
        wrDataRdy = 1'b0;
        applyStimulus();
        checkOutput("writeCmd", cmd, 3'b000);
        checkOutput("writeAddr", addr, 27'h0001234);
        applyStimulus();
        repeat (3) applyStimulus();
        wrDataRdy = 1'b1;
        applyStimulus();
        reqIf.req_valid_i = '0;
        wrDataRdy = 1'b0;
        applyStimulus();
        checkOutput("wrEnCycles", wrEnCount, 4);
        checkOutput("wrReadyCount", readyVal.size(), 1);
        if (readyVal.size() == 1) checkOutput("wrReadyPort", readyVal[0], 2'b10);

        // Fifth read stalls until the tracking FIFO has room again
        readyVal.delete();
        rspVal.delete();
        newRequest(0, 1'b0);
        repeat (12) begin
            applyStimulus();
            renewAcked();
        end
        checkOutput("fullStallCount", readyVal.size(), 4);
        rdDataValid = 1'b1;
        rdData      = randData();
        applyStimulus();
        rdDataValid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("fullResumeCount", readyVal.size(), 5);
        reqIf.req_valid_i = '0;
        rdDataValid = 1'b1;
        repeat (4) begin
            rdData = randData();
            applyStimulus();
        end
        rdDataValid = 1'b0;
        applyStimulus();
        checkOutput("fullRspCount", rspVal.size(), 5);
        foreach (rspVal[i]) checkOutput("fullRspPort", rspVal[i], 2'b01);

        // Unexpected read data, then reset in the middle of a write
        rdDataValid = 1'b1;
        rdData      = randData();
        applyStimulus();
        rdDataValid = 1'b0;
        applyStimulus();
        checkOutput("rdErrSet", rdErr, 1'b1);
        applyStimulus();
        applyStimulus();
        checkOutput("rdErrSticky", rdErr, 1'b1);
        newRequest(0, 1'b1);
        cmdReady  = 1'b1;
        wrDataRdy = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("midWdataEn", wrDataEn, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rstCmdEn", cmdEn, 1'b0);
        checkOutput("rstWrEn", wrDataEn, 1'b0);
        checkOutput("rstWrEnd", wrDataEnd, 1'b0);
        checkOutput("rstWrData", wrData, '0);
        checkOutput("rstWrMask", wrDataMask, '0);
        checkOutput("rstReady", reqIf.req_ready_o, 2'b00);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstRdErr", rdErr, 1'b0);
        applyStimulus();
        reqIf.req_valid_i = '0;
        reset     = 1'b0;
        calibDone = 1'b0;
        repeat (3) applyStimulus();
        newRequest(0, 1'b0);
        calibDone = 1'b1;
        applyStimulus();
        checkOutput("postRstWaitCalib", cmdEn, 1'b0);
        applyStimulus();
        checkOutput("postRstCmdEn", cmdEn, 1'b1);
        applyStimulus();
        reqIf.req_valid_i = '0;
        rdDataValid = 1'b1;
        rdData      = randData();
        applyStimulus();
        rdDataValid = 1'b0;

        // Random traffic on both ports
        repeat (400) driveRandomCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/ddr3_port_arbiter.md
DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter AddrWidth, default 27, DDR3 user-interface address width.
REQ-003 SHALL have parameter DataWidth, default 256, user-interface data beat width; MaskWidth = DataWidth/8.
REQ-004 SHALL have parameter MaxRdOut, default 4, maximum outstanding read commands (power of two).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-006 calib_done_i  in  1  controller init_calib_complete.
REQ-007 req_valid_i  in  NumReq  per-port request valid, held with its payload until req_ready_o.
REQ-008 req_write_i  in  NumReq  per-port 1 = write, 0 = read.
REQ-009 req_addr_i  in  NumReq x AddrWidth  per-port address.
REQ-010 req_wdata_i / req_wmask_i  in  NumReq x DataWidth / NumReq x MaskWidth  per-port write beat and mask (1 = masked byte).
REQ-011 req_ready_o  in/out: out  NumReq  one-cycle acceptance pulse.
REQ-012 rsp_valid_o  out  NumReq  one-hot read-data strobe; rsp_data_o  out  DataWidth  shared read data.
REQ-013 cmd_ready_i  in  1; cmd_en_o  out  1; cmd_o  out  3 (write 3'b000, read 3'b001); addr_o  out  AddrWidth.
REQ-014 wr_data_rdy_i  in  1; wr_data_en_o, wr_data_end_o  out  1; wr_data_o  out  DataWidth; wr_data_mask_o  out  MaskWidth.
REQ-015 rd_data_valid_i  in  1; rd_data_i  in  DataWidth.
REQ-016 busy_o  out  1  state not IDLE/WAIT_CALIB; rd_err_o  out  1  sticky unexpected read data.

Function
REQ-017 FSM states WAIT_CALIB, IDLE, CMD, WDATA; reset state WAIT_CALIB.
REQ-018 WAIT_CALIB -> IDLE on first cycle calib_done_i = 1; never re-entered except by reset.
REQ-019 IDLE: if calib_done_i = 1 and any eligible req_valid_i, grant one port, latch its index, -> CMD next cycle; calib_done_i = 0 blocks new grants only.
REQ-020 Eligible = req_valid_i set and (write, or read-tracking FIFO not full).
REQ-021 Round-robin: search starts at (last_grant+1) mod NumReq; last_grant resets to NumReq-1, so port 0 wins first.
REQ-022 CMD: cmd_en_o = 1, cmd_o/addr_o from granted port; command accepted when cmd_en_o and cmd_ready_i both 1.
REQ-023 Read accepted: push port index into FIFO, pulse req_ready_o[grant], -> IDLE.
REQ-024 Write accepted: -> WDATA; no req_ready_o yet.
REQ-025 WDATA: wr_data_en_o = wr_data_end_o = 1, data/mask from granted port; on wr_data_rdy_i = 1 pulse req_ready_o[grant], -> IDLE.
REQ-026 Minimum cycles per request: read 2 (IDLE, CMD), write 3 (IDLE, CMD, WDATA); stalls extend CMD/WDATA indefinitely.
REQ-027 Read return: on rd_data_valid_i with FIFO non-empty, same cycle rsp_valid_o[head] = 1, rsp_data_o = rd_data_i, pop; no backpressure.
REQ-028 rd_data_valid_i with FIFO empty: no rsp_valid_o, set rd_err_o until reset.
REQ-029 Simultaneous push and pop: both performed, occupancy unchanged; full = MaxRdOut entries, pointers wrap modulo MaxRdOut.
REQ-030 Requester dropping req_valid_i while granted is illegal; behaviour unspecified, no assertion required in RTL.
REQ-031 cmd_en_o, wr_data_en_o outside CMD/WDATA SHALL be 0; payload outputs SHALL be 0 when not enabled.

Reset
REQ-032 rst_i asserted at any time immediately forces: state WAIT_CALIB, FIFO empty, last_grant NumReq-1, rd_err_o 0, all outputs 0; in-flight transactions discarded.

Verification
REQ-033 Calib gating: req_valid_i=2'b01 with calib_done_i=0 for 20 cycles -> cmd_en_o stays 0; raise calib -> cmd_en_o=1 two cycles later.
REQ-034 Round-robin: both ports request reads continuously, cmd_ready_i=1 -> grant order 0,1,0,1; req_ready_o pulses every 2 cycles.
REQ-035 Write: port 1 write addr 0x0001234, wr_data_rdy_i delayed 3 cycles -> wr_data_en_o held 4 cycles, req_ready_o=2'b10 once.
REQ-036 FIFO full: MaxRdOut=4, 5 reads from port 0 with no rd_data_valid_i -> 5th not granted until one rd_data_valid_i, then issued; routing returns rsp_valid_o=2'b01 each.
REQ-037 Error and reset: rd_data_valid_i with empty FIFO -> rd_err_o=1 sticky; rst_i pulse mid-WDATA -> all outputs 0, state WAIT_CALIB.
